control_sequencer: RTL

// - Multi-cycle main control FSM of the RV64F core; consumes one-hot opcode class code[31:0] from opdecoder.
// - Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives datapath enables.
// - Handshakes with instruction/data memory (req/ready) and the multi-cycle FPU (start/done); traps unsupported opcodes.

---
 rtl/control_sequencer_if.sv | 31 +++
 rtl/control_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the main sequencer and the datapath/memory/FPU side.
// master = sequencer (drives enables), slave = datapath side (drives code and completions).
interface control_sequencer_if;
    logic [31:0] code;
    logic        mem_ready;
    logic        fpu_done;
    logic        branch_taken;
    logic        ir_write;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        fpu_start;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        reg_write;
    logic        freg_write;
    logic        trap;
    logic [2:0]  state;

    modport master (
        input  code, mem_ready, fpu_done, branch_taken,
        output ir_write, imem_req, dmem_req, dmem_we, fpu_start, pc_write,
               pc_sel, reg_write, freg_write, trap, state
    );

    modport slave (
        output code, mem_ready, fpu_done, branch_taken,
        input  ir_write, imem_req, dmem_req, dmem_we, fpu_start, pc_write,
               pc_sel, reg_write, freg_write, trap, state
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM for the RV64F core.
// Optional CTRL_PERF_COUNTERS_EN adds free-running cycle and retired-instruction counters.
module control_sequencer #(
    parameter int FPU_TIMEOUT = 64,
    parameter int CNT_W       = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_sequencer_if.master  bus
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_t;

    localparam logic [31:0] INT_MASK    = 32'h0000_7070;
    localparam logic [31:0] FP_MASK     = 32'h001F_0000;
    localparam logic [31:0] LS_MASK     = 32'h0000_0303;
    localparam logic [31:0] STORE_MASK  = 32'h0000_0300;
    localparam logic [31:0] NOP_MASK    = 32'h1000_0008;
    localparam logic [31:0] BRANCH_MASK = 32'h0100_0000;
    localparam logic [31:0] JALR_MASK   = 32'h0200_0000;
    localparam logic [31:0] JAL_MASK    = 32'h0800_0000;
    localparam logic [31:0] SUPPORTED   = INT_MASK | FP_MASK | LS_MASK | NOP_MASK
                                        | BRANCH_MASK | JALR_MASK | JAL_MASK;
    localparam logic [31:0] INT_WB_MASK = INT_MASK | 32'h0000_0001 | JALR_MASK | JAL_MASK;
    localparam logic [31:0] FP_WB_MASK  = FP_MASK | 32'h0000_0002;
    localparam logic [7:0]  FPU_LAST    = 8'(FPU_TIMEOUT - 1);

    state_t      state_reg;
    logic [31:0] code_q_reg;
    logic [7:0]  fpu_cnt_reg;

    logic [31:0] code;
    logic        code_ok;
    logic        is_nop;
    logic        fp_q, ls_q, store_q, branch_q, jal_q, jalr_q, int_wb_q, fp_wb_q;

    logic        ir_write, imem_req, dmem_req, dmem_we, fpu_start, pc_write;
    logic [1:0]  pc_sel;
    logic        reg_write, freg_write;

    assign code = bus.code;

    // Unsupported classes (including AMO, bit 11) fall outside SUPPORTED and trap.
    assign code_ok = (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0)
                   && ((code & SUPPORTED) != 32'd0);
    assign is_nop  = (code & NOP_MASK) != 32'd0;

    assign fp_q     = (code_q_reg & FP_MASK)     != 32'd0;
    assign ls_q     = (code_q_reg & LS_MASK)     != 32'd0;
    assign store_q  = (code_q_reg & STORE_MASK)  != 32'd0;
    assign branch_q = (code_q_reg & BRANCH_MASK) != 32'd0;
    assign jal_q    = (code_q_reg & JAL_MASK)    != 32'd0;
    assign jalr_q   = (code_q_reg & JALR_MASK)   != 32'd0;
    assign int_wb_q = (code_q_reg & INT_WB_MASK) != 32'd0;
    assign fp_wb_q  = (code_q_reg & FP_WB_MASK)  != 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            code_q_reg  <= 32'd0;
            fpu_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (bus.mem_ready) state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    code_q_reg  <= code;
                    fpu_cnt_reg <= 8'd0;
                    if (!code_ok)    state_reg <= S_TRAP;
                    else if (is_nop) state_reg <= S_FETCH;
                    else             state_reg <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (fp_q) begin
                        // A done on the final allowed cycle still completes normally.
                        if (bus.fpu_done)                state_reg <= S_WRITEBACK;
                        else if (fpu_cnt_reg == FPU_LAST) state_reg <= S_TRAP;
                        fpu_cnt_reg <= fpu_cnt_reg + 8'd1;
                    end else if (ls_q) begin
                        state_reg <= S_MEM;
                    end else if (branch_q) begin
                        state_reg <= S_FETCH;
                    end else begin
                        state_reg <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) state_reg <= store_q ? S_FETCH : S_WRITEBACK;
                end
                S_WRITEBACK: state_reg <= S_FETCH;
                S_TRAP:      state_reg <= S_TRAP;
                default:     state_reg <= S_TRAP;
            endcase
        end
    end

    // Enables are forced low while rst_n is asserted so a dropped request never leaks out.
    always_comb begin
        ir_write   = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        fpu_start  = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 2'b00;
        reg_write  = 1'b0;
        freg_write = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = bus.mem_ready;
                end
                S_DECODE: begin
                    pc_write = code_ok && is_nop;
                end
                S_EXECUTE: begin
                    if (fp_q) begin
                        fpu_start = (fpu_cnt_reg == 8'd0);
                    end else if (branch_q) begin
                        pc_write = 1'b1;
                        pc_sel   = bus.branch_taken ? 2'b01 : 2'b00;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = store_q;
                    pc_write = store_q && bus.mem_ready;
                end
                S_WRITEBACK: begin
                    pc_write   = 1'b1;
                    reg_write  = int_wb_q;
                    freg_write = fp_wb_q && !int_wb_q;
                    if (jal_q)       pc_sel = 2'b10;
                    else if (jalr_q) pc_sel = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign bus.ir_write   = ir_write;
    assign bus.imem_req   = imem_req;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.fpu_start  = fpu_start;
    assign bus.pc_write   = pc_write;
    assign bus.pc_sel     = pc_sel;
    assign bus.reg_write  = reg_write;
    assign bus.freg_write = freg_write;
    assign bus.trap       = (state_reg == S_TRAP);
    assign bus.state      = state_reg;

`ifdef CTRL_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instret_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else if (state_reg != S_TRAP) begin
            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (pc_write) instret_cnt_reg <= instret_cnt_reg + 1'b1;
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`endif

endmodule
